// File: rtl/inst_sequencer.sv
// Purpose: emits the 34-bit core instruction word for one full tile pass.
// Latency: inst/busy/done are registered; the first W_FETCH word appears the cycle after start.
// Backpressure: the write-back phase stalls while ofifo_valid is low; there is no timeout.
module inst_sequencer #(
   parameter int row    = 8,
   parameter int col    = 8,
   parameter int addr_w = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              acc,
   input  logic [addr_w-1:0] num_act,
   input  logic [addr_w-1:0] w_base,
   input  logic [addr_w-1:0] a_base,
   input  logic [addr_w-1:0] p_base,
   input  logic              ofifo_valid,
   output logic [33:0]       inst,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = addr_w + 1;
   localparam logic [33:0]       IDLE_WORD  = 34'h1_800C_0000;
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [addr_w-1:0] ADDR_ONE   = addr_w'(1);
   localparam logic [CNT_W-1:0]  COL_LEN    = CNT_W'(col);
   localparam logic [CNT_W-1:0]  LOAD_LAST  = CNT_W'(col - 1);
   localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(row + col - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_W_FETCH, ST_W_LOAD, ST_W_DRAIN,
      ST_A_FETCH, ST_EXEC, ST_WB, ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [addr_w-1:0] rd_cnt_q, rd_cnt_d;
   logic [addr_w-1:0] wr_cnt_q, wr_cnt_d;
   logic              acc_q, acc_d;
   logic [addr_w-1:0] num_q, num_d;
   logic [addr_w-1:0] w_base_q, w_base_d;
   logic [addr_w-1:0] a_base_q, a_base_d;
   logic [addr_w-1:0] p_base_q, p_base_d;
   logic [33:0]       inst_q, inst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_issue, wr_issue;

   // Next state, phase counter, config latch and write-back read/write issue.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      acc_d    = acc_q;
      num_d    = num_q;
      w_base_d = w_base_q;
      a_base_d = a_base_q;
      p_base_d = p_base_q;
      rd_issue = 1'b0;
      wr_issue = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_W_FETCH;
               cnt_d    = '0;
               rd_cnt_d = '0;
               wr_cnt_d = '0;
               acc_d    = acc;
               num_d    = num_act;
               w_base_d = w_base;
               a_base_d = a_base;
               p_base_d = p_base;
            end
         end
         ST_W_FETCH: begin
            if (cnt_q == COL_LEN) begin
               state_d = ST_W_LOAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_W_LOAD: begin
            if (cnt_q == LOAD_LAST) begin
               state_d = ST_W_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_W_DRAIN: begin
            if (cnt_q == DRAIN_LAST) begin
               state_d = (num_q != '0) ? ST_A_FETCH : ST_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_A_FETCH: begin
            if (cnt_q == {1'b0, num_q}) begin
               state_d = ST_EXEC;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_EXEC: begin
            if (cnt_q == ({1'b0, num_q} - CNT_ONE)) begin
               state_d = ST_WB;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_WB: begin
            if (wr_cnt_q == num_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A pop is issued only when the FIFO showed data; its pmem write lands one cycle later.
      if (state_d == ST_WB) begin
         if ((rd_cnt_q != num_q) && ofifo_valid) begin
            rd_issue = 1'b1;
            rd_cnt_d = rd_cnt_q + ADDR_ONE;
         end
         if (inst_q[6]) begin
            wr_issue = 1'b1;
            wr_cnt_d = wr_cnt_q + ADDR_ONE;
         end
      end
   end

   // Decode the word for the cycle being entered so inst lines up with state_q.
   always_comb begin
      inst_d = IDLE_WORD;
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
      case (state_d)
         ST_W_FETCH: begin
            if (cnt_d < COL_LEN) begin
               inst_d[19]   = 1'b0;
               inst_d[17:7] = w_base_d + cnt_d[addr_w-1:0];
            end
            inst_d[2] = (cnt_d != '0);
         end
         ST_W_LOAD: begin
            inst_d[3] = 1'b1;
            inst_d[0] = 1'b1;
         end
         ST_A_FETCH: begin
            if (cnt_d < {1'b0, num_d}) begin
               inst_d[19]   = 1'b0;
               inst_d[17:7] = a_base_d + cnt_d[addr_w-1:0];
            end
            inst_d[2] = (cnt_d != '0);
         end
         ST_EXEC: begin
            inst_d[3] = 1'b1;
            inst_d[1] = 1'b1;
         end
         ST_WB: begin
            inst_d[6] = rd_issue;
            if (wr_issue) begin
               inst_d[33]    = acc_d;
               inst_d[32]    = 1'b0;
               inst_d[31]    = 1'b0;
               inst_d[30:20] = p_base_d + wr_cnt_q;
            end
         end
         default: begin
            inst_d = IDLE_WORD;
         end
      endcase
   end

   // State, counters, latched config and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         acc_q    <= 1'b0;
         num_q    <= '0;
         w_base_q <= '0;
         a_base_q <= '0;
         p_base_q <= '0;
         inst_q   <= IDLE_WORD;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         acc_q    <= acc_d;
         num_q    <= num_d;
         w_base_q <= w_base_d;
         a_base_q <= a_base_d;
         p_base_q <= p_base_d;
         inst_q   <= inst_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign inst = inst_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Purpose: checks inst_sequencer cycle by cycle against a phase-level trace model.
// Latency: outputs sampled 1ns after each rising edge; inputs driven right after sampling.
// Backpressure: ofifo_valid patterns are constant-high, 1-0-0 repeating, or random.
module tb_inst_sequencer;

   localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
   localparam int ROW = 8;
   localparam int COL = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        acc;
   logic [10:0] num_act;
   logic [10:0] w_base;
   logic [10:0] a_base;
   logic [10:0] p_base;
   logic        ofifo_valid;
   logic [33:0] inst;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   inst_sequencer #(.row(ROW), .col(COL), .addr_w(11)) dut (
      .clk(clk), .reset(reset), .start(start), .acc(acc),
      .num_act(num_act), .w_base(w_base), .a_base(a_base), .p_base(p_base),
      .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int cyc, input logic [33:0] got, input logic [33:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, expv);
      end
   endtask

   task automatic chk_idle(input string tag, input int cyc);
      chk({tag, "_inst"}, cyc, inst, IDLE_W);
      chk({tag, "_busy"}, cyc, {33'b0, busy}, 34'd0);
      chk({tag, "_done"}, cyc, {33'b0, done}, 34'd0);
   endtask

   // Fetch cycle i of a lim-word fetch: SRAM read for i<lim, L0 write one cycle behind.
   function automatic logic [33:0] fetch_word(input int i, input int lim, input logic [10:0] base);
      logic [33:0] w;
      w = IDLE_W;
      if (i < lim) begin
         w[19]   = 1'b0;
         w[17:7] = base + 11'(i);
      end
      if (i >= 1) w[2] = 1'b1;
      return w;
   endfunction

   function automatic int exec_first(input int n);
      return (COL + 1) + COL + (ROW + COL) + (n + 1);
   endfunction

   task automatic scramble_inputs();
      acc     = 1'($urandom);
      num_act = 11'($urandom);
      w_base  = 11'($urandom);
      a_base  = 11'($urandom);
      p_base  = 11'($urandom);
   endtask

   task automatic run_pass(input logic acc_i, input int n, input logic [10:0] wb, input logic [10:0] ab,
                           input logic [10:0] pb, input int mode, input int poke, input int stop_at);
      logic [33:0] exp_q[$];
      bit          vld_a [0:1023];
      logic [33:0] w;
      int          rds, wrs, t, busy_cnt, done_cnt, wr_cnt, exp_busy;
      bit          prev_rd, rd;
      for (int k = 0; k < 1024; k++) begin
         case (mode)
            0:       vld_a[k] = 1'b1;
            1:       vld_a[k] = (k % 3 == 0);
            default: vld_a[k] = (k % 4 == 3) ? 1'b1 : 1'($urandom);
         endcase
      end
      for (int i = 0; i <= COL; i++) exp_q.push_back(fetch_word(i, COL, wb));
      for (int i = 0; i < COL; i++) begin
         w = IDLE_W; w[3] = 1'b1; w[0] = 1'b1;
         exp_q.push_back(w);
      end
      for (int i = 0; i < ROW + COL; i++) exp_q.push_back(IDLE_W);
      if (n > 0) begin
         for (int i = 0; i <= n; i++) exp_q.push_back(fetch_word(i, n, ab));
         for (int i = 0; i < n; i++) begin
            w = IDLE_W; w[3] = 1'b1; w[1] = 1'b1;
            exp_q.push_back(w);
         end
         rds = 0; wrs = 0; prev_rd = 1'b0; t = exp_q.size();
         do begin
            w  = IDLE_W;
            rd = (rds < n) && vld_a[t-1];
            if (rd) begin
               rds++;
               w[6] = 1'b1;
            end
            if (prev_rd) begin
               w[33]    = acc_i;
               w[32]    = 1'b0;
               w[31]    = 1'b0;
               w[30:20] = pb + 11'(wrs);
               wrs++;
            end
            exp_q.push_back(w);
            prev_rd = rd;
            t++;
         end while (wrs < n);
      end
      exp_q.push_back(IDLE_W);

      acc = acc_i; num_act = 11'(n); w_base = wb; a_base = ab; p_base = pb;
      ofifo_valid = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy_cnt = 0; done_cnt = 0; wr_cnt = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
         chk("inst", k, inst, exp_q[k]);
         chk("busy", k, {33'b0, busy}, 34'd1);
         chk("done", k, {33'b0, done}, (k == exp_q.size() - 1) ? 34'd1 : 34'd0);
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (!inst[32] && !inst[31]) wr_cnt++;
         if (inst[6] && k > 0) chk("rd_vld", k, {33'b0, vld_a[k-1]}, 34'd1);
         scramble_inputs();
         start = (k == poke);
         ofifo_valid = vld_a[k];
         if (k == stop_at) return;
         @(posedge clk); #1;
      end
      ofifo_valid = 1'b0;
      start = 1'b0;
      chk_idle("end", exp_q.size());
      exp_busy = (n == 0) ? 34 : 3 * n + 36;
      if (mode == 0) chk("busy_len", n, 34'(busy_cnt), 34'(exp_busy));
      chk("done_pulses", n, 34'(done_cnt), 34'd1);
      chk("pmem_writes", n, 34'(wr_cnt), 34'(n));
   endtask

   initial begin
      int n;
      reset = 1'b0; start = 1'b0; acc = 1'b0; num_act = '0;
      w_base = '0; a_base = '0; p_base = '0; ofifo_valid = 1'b0;

      // Reset held with inputs toggling.
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk_idle("rst_hold", k);
         scramble_inputs();
         start = 1'($urandom);
         ofifo_valid = 1'($urandom);
      end
      start = 1'b0;
      #2 reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk_idle("post_rst", k);
         scramble_inputs();
         ofifo_valid = 1'($urandom);
      end

      // Directed passes: weight phase / full pass with busy poke, back-pressure, corners.
      run_pass(1'b1, 4, 11'h010, 11'h020, 11'h100, 0, exec_first(4) + 1, -1);
      run_pass(1'b1, 4, 11'h010, 11'h020, 11'h100, 1, -1, -1);
      run_pass(1'b0, 0, 11'h010, 11'h020, 11'h100, 0, -1, -1);
      run_pass(1'b1, 3, 11'h7FC, 11'h7FE, 11'h7FE, 0, exec_first(3), -1);

      // Randomized passes.
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(0, 6);
         run_pass(1'($urandom), n, 11'($urandom), 11'($urandom), 11'($urandom),
                  $urandom_range(0, 2), exec_first(n) + 1, -1);
      end

      // Reset during EXEC, then a complete pass afterwards.
      run_pass(1'b1, 4, 11'h010, 11'h020, 11'h100, 0, -1, exec_first(4) + 1);
      #2 reset = 1'b0;
      #1;
      chk_idle("rst_mid", 0);
      start = 1'b0;
      @(posedge clk); #1;
      chk_idle("rst_mid_hold", 1);
      #2 reset = 1'b1;
      run_pass(1'b0, 5, 11'h030, 11'h040, 11'h200, 2, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
